// File: rtl/sampling_frame_scheduler.sv
// Round-robin frame scheduler sharing one pooling sampler between NUM_CH channel buffers.
// Grant is registered 1 cycle after Req is sampled in IDLE; the granted channel keeps the sampler until its frame completes.
module sampling_frame_scheduler #(
   parameter int DATA_W       = 16,
   parameter int NUM_CH       = 4,
   parameter int CH_W         = 2,
   parameter int FRAME_PIXELS = 64,
   parameter int ADDR_W       = 6,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [NUM_CH-1:0] Req,
   output logic [NUM_CH-1:0] Grant,
   output logic [NUM_CH-1:0] Done,
   output logic              Rd_En,
   output logic [ADDR_W-1:0] Rd_Addr,
   input  logic [DATA_W-1:0] Rd_Data,
   output logic [DATA_W-1:0] Smp_Pixel,
   output logic              Smp_Valid,
   output logic              Smp_Finish,
   output logic              Smp_Reset,
   input  logic              Smp_Out_Finish,
   output logic [CH_W-1:0]   Out_Channel,
   output logic              Busy,
   output logic              Err
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_FINISH, S_RELEASE} state_t;

   localparam logic [ADDR_W:0]   PIX_TOTAL = (ADDR_W+1)'(FRAME_PIXELS);
   localparam logic [7:0]        WAIT_MAX  = 8'(DONE_TIMEOUT);
   localparam logic [CH_W-1:0]   PTR_RST   = CH_W'(NUM_CH-1);
   localparam logic [NUM_CH-1:0] GRANT_ONE = NUM_CH'(1);
   localparam logic [CH_W:0]     CH_COUNT  = (CH_W+1)'(NUM_CH);

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] grant_q, grant_d;
   logic [NUM_CH-1:0] done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              data_vld_q, data_vld_d;
   logic [DATA_W-1:0] smp_pixel_q, smp_pixel_d;
   logic              smp_valid_q, smp_valid_d;
   logic              smp_finish_q, smp_finish_d;
   logic              smp_reset_q, smp_reset_d;
   logic [CH_W-1:0]   out_ch_q, out_ch_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]   pix_cnt_q, pix_cnt_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;

   logic              arb_found;
   logic [CH_W-1:0]   arb_winner;
   logic [CH_W:0]     arb_idx;

   // Search starts just after the last-served channel and wraps.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = '0;
      arb_idx    = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         arb_idx = {1'b0, ptr_q} + (CH_W+1)'(i);
         if (arb_idx >= CH_COUNT) arb_idx = arb_idx - CH_COUNT;
         if (!arb_found && Req[arb_idx[CH_W-1:0]]) begin
            arb_found  = 1'b1;
            arb_winner = arb_idx[CH_W-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      done_d       = '0;
      rd_en_d      = 1'b0;
      rd_addr_d    = '0;
      data_vld_d   = 1'b0;
      smp_pixel_d  = data_vld_q ? Rd_Data : '0;
      smp_valid_d  = data_vld_q;
      smp_finish_d = smp_finish_q;
      smp_reset_d  = 1'b0;
      out_ch_d     = out_ch_q;
      busy_d       = busy_q;
      err_d        = err_q;
      ptr_d        = ptr_q;
      pix_cnt_d    = pix_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               state_d     = S_CLEAR;
               grant_d     = GRANT_ONE << arb_winner;
               out_ch_d    = arb_winner;
               busy_d      = 1'b1;
               smp_reset_d = 1'b1;
            end
         end
         S_CLEAR: begin
            state_d   = S_STREAM;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            pix_cnt_d = (ADDR_W+1)'(1);
         end
         S_STREAM: begin
            data_vld_d = rd_en_q;
            if (pix_cnt_q < PIX_TOTAL) begin
               rd_en_d   = 1'b1;
               rd_addr_d = pix_cnt_q[ADDR_W-1:0];
               pix_cnt_d = pix_cnt_q + 1'b1;
            end else if (!rd_en_q && !data_vld_q && smp_valid_q) begin
               // Last pixel is on the sampler now; Finish rises as Valid falls.
               state_d      = S_FINISH;
               smp_finish_d = 1'b1;
               wait_cnt_d   = '0;
            end
         end
         S_FINISH: begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (Smp_Out_Finish || wait_cnt_d == WAIT_MAX) begin
               state_d      = S_RELEASE;
               smp_finish_d = 1'b0;
               done_d       = grant_q;
               ptr_d        = out_ch_q;
               if (!Smp_Out_Finish) err_d = 1'b1;
            end
         end
         S_RELEASE: begin
            state_d  = S_IDLE;
            grant_d  = '0;
            out_ch_d = '0;
            busy_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         done_q       <= '0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         data_vld_q   <= 1'b0;
         smp_pixel_q  <= '0;
         smp_valid_q  <= 1'b0;
         smp_finish_q <= 1'b0;
         smp_reset_q  <= 1'b0;
         out_ch_q     <= '0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         ptr_q        <= PTR_RST;
         pix_cnt_q    <= '0;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         done_q       <= done_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         data_vld_q   <= data_vld_d;
         smp_pixel_q  <= smp_pixel_d;
         smp_valid_q  <= smp_valid_d;
         smp_finish_q <= smp_finish_d;
         smp_reset_q  <= smp_reset_d;
         out_ch_q     <= out_ch_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         ptr_q        <= ptr_d;
         pix_cnt_q    <= pix_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   assign Grant       = grant_q;
   assign Done        = done_q;
   assign Rd_En       = rd_en_q;
   assign Rd_Addr     = rd_addr_q;
   assign Smp_Pixel   = smp_pixel_q;
   assign Smp_Valid   = smp_valid_q;
   assign Smp_Finish  = smp_finish_q;
   assign Smp_Reset   = smp_reset_q;
   assign Out_Channel = out_ch_q;
   assign Busy        = busy_q;
   assign Err         = err_q;

endmodule

// File: tb/tb_sampling_frame_scheduler.sv
// Directed bench for sampling_frame_scheduler with a buffer model and a sampler Out_Finish model.
module tb_sampling_frame_scheduler;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [3:0]  Req = '0;
   logic [3:0]  Grant, Done;
   logic        Rd_En;
   logic [5:0]  Rd_Addr;
   logic [15:0] rd_data = '0;
   logic [15:0] Smp_Pixel;
   logic        Smp_Valid, Smp_Finish, Smp_Reset;
   logic        Smp_Out_Finish;
   logic [1:0]  Out_Channel;
   logic        Busy, Err;

   int total = 0;
   int bad = 0;
   int fin_delay = 5;
   int fin_cnt = 0;

   sampling_frame_scheduler dut (
      .Clock(Clock), .Reset(Reset), .Req(Req), .Grant(Grant), .Done(Done),
      .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(rd_data),
      .Smp_Pixel(Smp_Pixel), .Smp_Valid(Smp_Valid), .Smp_Finish(Smp_Finish),
      .Smp_Reset(Smp_Reset), .Smp_Out_Finish(Smp_Out_Finish),
      .Out_Channel(Out_Channel), .Busy(Busy), .Err(Err)
   );

   always #5 Clock = ~Clock;

   // Channel buffer: data is {channel, address}, one cycle after the read strobe.
   always @(posedge Clock) if (Rd_En) rd_data <= (16'(Out_Channel) << 8) | 16'(Rd_Addr);

   // Sampler: Out_Finish after fin_delay cycles of Finish; fin_delay < 0 means never.
   always @(posedge Clock) fin_cnt <= Smp_Finish ? fin_cnt + 1 : 0;
   assign Smp_Out_Finish = (fin_delay >= 0) && Smp_Finish && (fin_cnt == fin_delay);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({Grant, Done, Rd_En, Rd_Addr, Smp_Pixel, Smp_Valid, Smp_Finish,
                  Smp_Reset, Out_Channel, Busy, Err});
   endfunction

   // Follow one frame of channel ch; optionally rewrite Req or assert Reset after a pixel count.
   task automatic do_frame(input int ch, input int fin_exp, input logic err_exp,
                           input int chg_at, input logic [3:0] chg_req, input int abort_at);
      logic [3:0] oh;
      int n, rd_cnt, addr_err, vld_cnt, pix_err, gaps, overlap, fin_cyc;
      int grant_err, rst_cnt, first_rd, first_vld;
      logic done_seen, prev_vld;
      oh = 4'b0001 << ch;
      n = 0;
      do begin
         @(negedge Clock);
         n++;
      end while (Grant == 4'b0 && n < 20);
      check("grant_wait", n, 1);
      check("grant", Grant, oh);
      check("out_ch", Out_Channel, ch);
      check("clear_cycle", {Smp_Reset, Busy, Rd_En, Smp_Valid, Smp_Finish}, 5'b11000);
      rd_cnt = 0; addr_err = 0; vld_cnt = 0; pix_err = 0; gaps = 0; overlap = 0;
      fin_cyc = 0; grant_err = 0; rst_cnt = 0; first_rd = -1; first_vld = -1;
      done_seen = 1'b0; prev_vld = 1'b0;
      for (int cyc = 1; cyc < 600 && !done_seen; cyc++) begin
         @(negedge Clock);
         if (Grant != oh || Out_Channel != 2'(ch) || !Busy) grant_err++;
         if (Smp_Reset) rst_cnt++;
         if (Rd_En) begin
            if (first_rd < 0) first_rd = cyc;
            if (Rd_Addr != 6'(rd_cnt)) addr_err++;
            rd_cnt++;
         end
         if (Smp_Valid) begin
            if (first_vld < 0) first_vld = cyc;
            if (vld_cnt > 0 && !prev_vld) gaps++;
            if (Smp_Pixel != 16'((ch << 8) | vld_cnt)) pix_err++;
            vld_cnt++;
         end
         prev_vld = Smp_Valid;
         if (Smp_Valid && Smp_Finish) overlap++;
         if (Smp_Finish) fin_cyc++;
         if (Done != 4'b0) done_seen = 1'b1;
         if (chg_at >= 0 && Smp_Valid && vld_cnt == chg_at) Req = chg_req;
         if (abort_at >= 0 && Smp_Valid && vld_cnt == abort_at) begin
            Reset = 1'b1;
            #1;
            check("abort_outs_zero", all_outs(), 64'd0);
            return;
         end
      end
      check("done", Done, oh);
      check("err", Err, err_exp);
      check("rd_count", rd_cnt, 64);
      check("rd_addr_seq", addr_err, 0);
      check("valid_count", vld_cnt, 64);
      check("pixel_seq", pix_err, 0);
      check("valid_gaps", gaps, 0);
      check("valid_latency", first_vld - first_rd, 2);
      check("valid_finish_overlap", overlap, 0);
      check("finish_cycles", fin_cyc, fin_exp);
      check("grant_held", grant_err, 0);
      check("single_smp_reset", rst_cnt, 0);
      @(negedge Clock);
      check("release_to_idle", {Grant, Busy, Done, Smp_Finish}, 10'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge Clock);
      check("reset_outs", all_outs(), 64'd0);
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      check("idle_no_req", {Grant, Busy, Smp_Reset}, 6'd0);

      // Single channel, sampler answers after 5 Finish cycles.
      fin_delay = 5;
      Req = 4'b0001;
      do_frame(0, 6, 1'b0, 1, 4'b0000, -1);
      repeat (3) @(negedge Clock);
      check("idle_after_t1", {Grant, Busy}, 5'd0);

      // Fresh pointer, all channels requesting: 0,1,2,3,0.
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      fin_delay = 3;
      Req = 4'b1111;
      do_frame(0, 4, 1'b0, -1, 4'b0000, -1);
      do_frame(1, 4, 1'b0, -1, 4'b0000, -1);
      do_frame(2, 4, 1'b0, -1, 4'b0000, -1);
      do_frame(3, 4, 1'b0, -1, 4'b0000, -1);
      do_frame(0, 4, 1'b0, -1, 4'b0000, -1);

      // ch1 drops its request mid-frame; frame still completes.
      do_frame(1, 4, 1'b0, 20, 4'b1101, -1);

      // ch2 sampler never finishes: timeout, sticky Err, ch3 served next.
      fin_delay = -1;
      do_frame(2, 255, 1'b1, -1, 4'b0000, -1);
      fin_delay = 3;
      do_frame(3, 4, 1'b1, 10, 4'b0010, -1);

      // Reset in the middle of ch1's frame; restart grants ch0 first from address 0.
      do_frame(1, 0, 1'b0, -1, 4'b0000, 30);
      @(negedge Clock);
      Reset = 1'b0;
      Req = 4'b0011;
      do_frame(0, 4, 1'b0, -1, 4'b0000, -1);

      // Pointer at ch1 with Req=1010: ch3 before ch1.
      do_frame(1, 4, 1'b0, 5, 4'b1010, -1);
      do_frame(3, 4, 1'b0, -1, 4'b0000, -1);
      do_frame(1, 4, 1'b0, 1, 4'b0000, -1);
      repeat (3) @(negedge Clock);
      check("final_idle", {Grant, Busy, Err}, 6'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
